usb_ep0_ctrl_seq: RTL
=====================

# usb_ep0_ctrl_seq

Endpoint-0 standard-request sequencer for the USB hub. It captures the 8-byte SETUP payload, decodes SET_ADDRESS and SET_CONFIGURATION, and runs the status stage: a zero-length DATA1 packet or a STALL. It then commits the result to the hub device-state FSM by pulsing `addr_set` / `cnfg_set`, and holds the device address and configuration value used by the rest of the hub.

## Interface
- No parameters.
- `clk` in 1 — sole clock.
- `rst_n` in 1 — reset, synchronous, active-low.
- `setup_start` in 1 — SETUP token to EP0 decoded; starts a new transaction (1-cycle pulse).
- `rx_valid` in 1 — `rx_byte` is valid this cycle.
- `rx_byte` in 8 — SETUP data payload byte, byte 0 first.
- `rx_done` in 1 — end of data packet, CRC good (1-cycle pulse).
- `rx_err` in 1 — data packet CRC/bit-stuff error (1-cycle pulse).
- `in_token` in 1 — IN token to EP0 (1-cycle pulse).
- `host_ack` in 1 — host ACK received for our last DATA1 (1-cycle pulse).
- `is_conf` in 1 — hub FSM is in the configured state.
- `zlp_send` out 1 — 1-cycle pulse: transmit a zero-length DATA1.
- `stall_send` out 1 — 1-cycle pulse: transmit STALL.
- `addr_set` out 1 — 1-cycle pulse to the hub FSM: address assigned.
- `cnfg_set` out 1 — 1-cycle pulse to the hub FSM: configuration selected.
- `dev_addr` out 7 — current device address.
- `cnfg_val` out 8 — current configuration value.
- `busy` out 1 — high in every state except IDLE.

## Operation
- **States:** IDLE, CAPTURE, DECODE, STATUS, ACKWAIT, COMMIT, STALLED.
- **Reset:** state IDLE. `dev_addr`=0, `cnfg_val`=0, all pulses 0, byte counter 0.
- **`setup_start` in any state** → CAPTURE next cycle, byte counter cleared. This overrides all other inputs in the same cycle and aborts any pending commit.
- **CAPTURE**
  - Each `rx_valid` stores `rx_byte` at index = counter (0..7), then the counter increments.
  - A 9th byte sets an overflow flag.
  - `rx_done` with counter==8 and no overflow → DECODE.
  - `rx_done` with short or overflowed payload, or `rx_err` → IDLE. No response is sent and no state changes.
  - If `rx_valid` and `rx_done` fall in the same cycle, the byte is counted first.
- **DECODE** (1 cycle) → STATUS if accepted, else STALLED.
  - *SET_ADDRESS:* b0=0x00, b1=0x05, b2[7]=0, b3..b7=0. Latch pending address b2[6:0]. Accept.
  - *SET_CONFIGURATION:* b0=0x00, b1=0x09, b3..b7=0, b2∈{0,1}, and `dev_addr`≠0. Latch pending config b2. Accept.
  - Anything else, including b2≥2 or SET_CONFIGURATION with `dev_addr`=0 → STALLED.
- **STATUS:** `in_token` → `zlp_send` pulse next cycle, → ACKWAIT.
- **ACKWAIT**
  - `host_ack` → COMMIT.
  - Repeat `in_token` (host retry) → `zlp_send` again, stay in ACKWAIT.
- **COMMIT** (1 cycle) → IDLE.
  - *SET_ADDRESS:* `dev_addr`←pending. `addr_set` pulses only if pending≠0 and old `dev_addr`=0.
  - *SET_CONFIGURATION:* `cnfg_val`←pending. `cnfg_set` pulses only if pending=1 and `is_conf`=0.
  - The address change takes effect only after the status stage is ACKed, never before.
- **STALLED:** every `in_token` → `stall_send` pulse next cycle. Stay in STALLED until `setup_start`.
- `zlp_send` and `stall_send` are never high in the same cycle.

## Timing
- Status response latency: `zlp_send` / `stall_send` is asserted exactly 1 cycle after `in_token`.
- `rx_done` cycle N → DECODE at N+1 → STATUS/STALLED at N+2.
- `host_ack` cycle M → COMMIT at M+1. `dev_addr`/`cnfg_val` update and the `addr_set`/`cnfg_set` pulse are all registered, visible at M+2.
- All outputs are registered. Pulses last exactly one cycle.
- `in_token` before DECODE completes, while still in CAPTURE/DECODE, is ignored (no response).
- `host_ack` outside ACKWAIT is ignored.
- Reset asserted mid-transaction: next cycle IDLE, `dev_addr`/`cnfg_val` back to 0, no pulse emitted.

## Test plan
- **SET_ADDRESS(0x2A):** bytes 00 05 2A 00 00 00 00 00, `rx_done`, `in_token` → `zlp_send` 1 cycle later. `host_ack` → `dev_addr`=0x2A and single `addr_set` pulse 2 cycles after ack.
- **SET_CONFIGURATION(1) after address 5, `is_conf`=0:** `zlp_send` on IN. After ack → `cnfg_val`=1 and one `cnfg_set` pulse. Repeat with `is_conf`=1 → `cnfg_val`=1, no pulse.
- **SET_CONFIGURATION(1) with `dev_addr`=0, or bRequest 0x06:** → STALLED. Each of 3 `in_token`s yields `stall_send`. Subsequent `setup_start` clears the stall.
- **Retry:** SET_ADDRESS(7), two `in_token`s before `host_ack` → two `zlp_send` pulses. `dev_addr` stays 0 until the ack, then becomes 7.
- **Malformed payload:** 7-byte payload, 9-byte payload, and `rx_err` → IDLE. `in_token` gets no response and `dev_addr` is unchanged.
- **Abort:** `setup_start` while in ACKWAIT for SET_ADDRESS(9), followed by `host_ack` → no commit and `dev_addr` unchanged. Reset in ACKWAIT → all outputs 0 next cycle.

Source files
------------

// File: rtl/usb_ep0_ctrl_seq_if.sv
// rtl/usb_ep0_ctrl_seq_if.sv - EP0 control sequencer token/data/response bundle
interface usb_ep0_ctrl_seq_if;
    logic       setup_start;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       rx_done;
    logic       rx_err;
    logic       in_token;
    logic       host_ack;
    logic       is_conf;
    logic       zlp_send;
    logic       stall_send;
    logic       addr_set;
    logic       cnfg_set;
    logic [6:0] dev_addr;
    logic [7:0] cnfg_val;
    logic       busy;

    modport master (
        output setup_start, rx_valid, rx_byte, rx_done, rx_err,
        output in_token, host_ack, is_conf,
        input  zlp_send, stall_send, addr_set, cnfg_set,
        input  dev_addr, cnfg_val, busy
    );

    modport slave (
        input  setup_start, rx_valid, rx_byte, rx_done, rx_err,
        input  in_token, host_ack, is_conf,
        output zlp_send, stall_send, addr_set, cnfg_set,
        output dev_addr, cnfg_val, busy
    );
endinterface

// File: rtl/usb_ep0_ctrl_seq.sv
// rtl/usb_ep0_ctrl_seq.sv - EP0 SET_ADDRESS/SET_CONFIGURATION request sequencer
module usb_ep0_ctrl_seq (
    input  logic              clk,
    input  logic              rst_n,
    usb_ep0_ctrl_seq_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_CAPTURE, S_DECODE, S_STATUS, S_ACKWAIT, S_COMMIT, S_STALLED
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_byte [8];
    logic [3:0] r_cnt;
    logic       r_ovf;
    logic       r_is_addr;
    logic [7:0] r_pend;
    logic [6:0] r_dev_addr;
    logic [7:0] r_cnfg_val;
    logic       r_zlp;
    logic       r_stall;
    logic       r_addr_set;
    logic       r_cnfg_set;
    logic       r_busy;

    logic       w_zlp_nxt;
    logic       w_stall_nxt;
    logic       w_take_byte;
    logic       w_ovf_byte;
    logic       w_rest_zero;
    logic       w_set_addr;
    logic       w_set_cfg;
    logic       w_len_ok;

    // A byte arriving in the same cycle as rx_done is counted before the length check
    assign w_take_byte = (r_state == S_CAPTURE) && bus.rx_valid && !r_cnt[3];
    assign w_ovf_byte  = (r_state == S_CAPTURE) && bus.rx_valid &&  r_cnt[3];
    assign w_len_ok    = ((w_take_byte ? r_cnt + 4'd1 : r_cnt) == 4'd8) && !(r_ovf || w_ovf_byte);

    assign w_rest_zero = (r_byte[3] | r_byte[4] | r_byte[5] | r_byte[6] | r_byte[7]) == 8'h00;
    assign w_set_addr  = (r_byte[0] == 8'h00) && (r_byte[1] == 8'h05) && !r_byte[2][7] && w_rest_zero;
    assign w_set_cfg   = (r_byte[0] == 8'h00) && (r_byte[1] == 8'h09) && (r_byte[2] <= 8'h01)
                         && w_rest_zero && (r_dev_addr != 7'd0);

    // Next-state and response-pulse decode; setup_start overrides everything
    always_comb begin
        w_state_nxt = r_state;
        w_zlp_nxt   = 1'b0;
        w_stall_nxt = 1'b0;
        if (bus.setup_start) begin
            w_state_nxt = S_CAPTURE;
        end else begin
            case (r_state)
                S_IDLE:    w_state_nxt = S_IDLE;
                S_CAPTURE: begin
                    if (bus.rx_err)       w_state_nxt = S_IDLE;
                    else if (bus.rx_done) w_state_nxt = w_len_ok ? S_DECODE : S_IDLE;
                end
                S_DECODE:  w_state_nxt = (w_set_addr || w_set_cfg) ? S_STATUS : S_STALLED;
                S_STATUS: begin
                    if (bus.in_token) begin
                        w_zlp_nxt   = 1'b1;
                        w_state_nxt = S_ACKWAIT;
                    end
                end
                S_ACKWAIT: begin
                    if (bus.host_ack)      w_state_nxt = S_COMMIT;
                    else if (bus.in_token) w_zlp_nxt   = 1'b1;
                end
                S_COMMIT:  w_state_nxt = S_IDLE;
                S_STALLED: w_stall_nxt = bus.in_token;
                default:   w_state_nxt = S_IDLE;
            endcase
        end
    end

    // State register and registered response pulses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_zlp   <= 1'b0;
            r_stall <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_zlp   <= w_zlp_nxt;
            r_stall <= w_stall_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
        end
    end

    // Payload capture, pending-request latch and post-ACK commit of address/config
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt      <= 4'd0;
            r_ovf      <= 1'b0;
            r_is_addr  <= 1'b0;
            r_pend     <= 8'd0;
            r_dev_addr <= 7'd0;
            r_cnfg_val <= 8'd0;
            r_addr_set <= 1'b0;
            r_cnfg_set <= 1'b0;
        end else begin
            r_addr_set <= 1'b0;
            r_cnfg_set <= 1'b0;
            if (bus.setup_start) begin
                r_cnt <= 4'd0;
                r_ovf <= 1'b0;
            end else begin
                if (w_take_byte) begin
                    r_byte[r_cnt[2:0]] <= bus.rx_byte;
                    r_cnt              <= r_cnt + 4'd1;
                end
                if (w_ovf_byte) begin
                    r_ovf <= 1'b1;
                end
                if (r_state == S_DECODE) begin
                    r_is_addr <= w_set_addr;
                    r_pend    <= w_set_addr ? {1'b0, r_byte[2][6:0]} : r_byte[2];
                end
                if (r_state == S_COMMIT) begin
                    if (r_is_addr) begin
                        r_dev_addr <= r_pend[6:0];
                        r_addr_set <= (r_pend[6:0] != 7'd0) && (r_dev_addr == 7'd0);
                    end else begin
                        r_cnfg_val <= r_pend;
                        r_cnfg_set <= (r_pend == 8'd1) && !bus.is_conf;
                    end
                end
            end
        end
    end

    assign bus.zlp_send   = r_zlp;
    assign bus.stall_send = r_stall;
    assign bus.addr_set   = r_addr_set;
    assign bus.cnfg_set   = r_cnfg_set;
    assign bus.dev_addr   = r_dev_addr;
    assign bus.cnfg_val   = r_cnfg_val;
    assign bus.busy       = r_busy;
endmodule
